// File: rtl/mode_sequencer_pkg.sv
// Shared mode encoding and digit-bus geometry for the front-panel controller
// and the mode blocks it drives.
package mode_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_ALARM = 2'd1,
        MODE_STOP  = 2'd2,
        MODE_TIMER = 2'd3
    } mode_t;

    localparam int NUM_MODES = 4;
    localparam int DIGIT_W   = 7;

    // TIMER wraps back to CLOCK through the natural 2-bit overflow.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/mode_sequencer_btn_conditioner.sv
// Push-button front end: multi-flop synchronizer, debounce counter and a
// single-cycle press pulse on the accepted 0->1 transition.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 20000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk_2MHz,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   level;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_lvl;
    logic                   settled;

    assign sync_lvl = sync_ff[SYNC_STAGES-1];

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so any bounce back restarts the qualification window.
    assign settled = (sync_lvl != level) && (cnt == CNT_LAST);

    // Pulse is taken from the acceptance condition itself, so it lines up
    // with the edge on which the debounced level rises.
    assign press = settled && sync_lvl;

    always_ff @(posedge clk_2MHz or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
            level   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_raw};
            if (sync_lvl == level) begin
                cnt <= '0;
            end else if (settled) begin
                level <= sync_lvl;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Front-panel controller: conditions MODE/SET/OP1, cycles the active mode,
// routes SET/OP1 strobes to that mode only and muxes its digits to the display.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                           clk_2MHz,
    input  logic                           reset,
    input  logic                           btn_mode,
    input  logic                           btn_set,
    input  logic                           btn_op1,
    input  logic [NUM_MODES*DIGIT_W-1:0]   mm_in,
    input  logic [NUM_MODES*DIGIT_W-1:0]   ss_in,
    input  logic [NUM_MODES*DIGIT_W-1:0]   ms_in,
    output logic [1:0]                     mode,
    output logic [NUM_MODES-1:0]           assert_vec,
    output logic                           in_set,
    output logic                           in_op1,
    output logic [DIGIT_W-1:0]             outMM,
    output logic [DIGIT_W-1:0]             outSS,
    output logic [DIGIT_W-1:0]             outMS
);

    logic  mode_press;
    logic  set_press;
    logic  op1_press;
    mode_t state;

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .SYNC_STAGES(SYNC_STAGES)) u_cond_mode (
        .clk_2MHz (clk_2MHz),
        .reset    (reset),
        .btn_raw  (btn_mode),
        .press    (mode_press)
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .SYNC_STAGES(SYNC_STAGES)) u_cond_set (
        .clk_2MHz (clk_2MHz),
        .reset    (reset),
        .btn_raw  (btn_set),
        .press    (set_press)
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .SYNC_STAGES(SYNC_STAGES)) u_cond_op1 (
        .clk_2MHz (clk_2MHz),
        .reset    (reset),
        .btn_raw  (btn_op1),
        .press    (op1_press)
    );

    assign mode = state;

    // A MODE press swallows any SET/OP1 arriving with it, so a strobe is
    // never delivered to a block that is just being left.
    always_ff @(posedge clk_2MHz or posedge reset) begin
        if (reset) begin
            state      <= MODE_CLOCK;
            assert_vec <= '0;
            in_set     <= 1'b0;
            in_op1     <= 1'b0;
            outMM      <= '0;
            outSS      <= '0;
            outMS      <= '0;
        end else begin
            outMM      <= mm_in[DIGIT_W*int'(state) +: DIGIT_W];
            outSS      <= ss_in[DIGIT_W*int'(state) +: DIGIT_W];
            outMS      <= ms_in[DIGIT_W*int'(state) +: DIGIT_W];
            assert_vec <= '0;
            in_set     <= 1'b0;
            in_op1     <= 1'b0;
            if (mode_press) begin
                state <= next_mode(state);
            end else if (set_press || op1_press) begin
                assert_vec[state] <= 1'b1;
                in_set            <= set_press;
                in_op1            <= op1_press;
            end
        end
    end

endmodule
